// File: rtl/rx_cfg_axil_arbiter_pkg.sv
// Shared types and constants for the RX_block_STA configuration-port arbiter.
package rx_cfg_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PROT_W = 3;
    localparam int unsigned RESP_W = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4
    } state_e;

    typedef enum logic {
        KIND_WR = 1'b0,
        KIND_RD = 1'b1
    } kind_e;

    localparam logic [RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PROT_W-1:0] prot;
    } axil_ax_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } axil_w_t;

endpackage

// File: rtl/rx_cfg_axil_arbiter_if.sv
// AXI4-Lite bundle; master drives requests, slave drives readies and responses.
interface rx_cfg_axil_if #(
    parameter int unsigned ADDR_WIDTH = rx_cfg_arb_pkg::ADDR_W,
    parameter int unsigned DATA_WIDTH = rx_cfg_arb_pkg::DATA_W
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

endinterface

// File: rtl/rx_cfg_axil_arbiter_rr_arb2.sv
// Two-requester round-robin picker; the pointer favours the port not served last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       advance,
    input  logic       last_port,
    output logic [1:0] gnt_c
);

    logic ptr_q;

    always_comb begin
        gnt_c = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt_c = ptr_q ? 2'b10 : 2'b01;
            else              gnt_c = req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ptr_q <= 1'b0;
        else if (advance) ptr_q <= ~last_port;
    end

endmodule

// File: rtl/rx_cfg_axil_arbiter.sv
// Serialises two AXI4-Lite masters onto one config slave, one transaction at a time.
module rx_cfg_axil_arbiter
    import rx_cfg_arb_pkg::*;
(
    input  logic                ACLK,
    input  logic                ARESET,
    rx_cfg_axil_if.slave        S0_AXI,
    rx_cfg_axil_if.slave        S1_AXI,
    rx_cfg_axil_if.master       M_AXI,
    output logic [1:0]          GRANT,
    output logic                BUSY
);

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] tog_q, tog_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       busy_q;

    logic [1:0] req_c, gnt_c;
    logic       adv_c;
    logic       pick_port_c;
    logic       pick_aw_c, pick_ar_c;
    kind_e      kind_c;

    logic       sel_p;
    axil_ax_t   sel_aw, sel_ar;
    axil_w_t    sel_w;
    logic       sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;

    logic       in_wr, in_b, in_ar, in_r;
    logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic       awready_c, wready_c, arready_c, bvalid_c, rvalid_c;

    assign req_c = {S1_AXI.awvalid | S1_AXI.arvalid, S0_AXI.awvalid | S0_AXI.arvalid};

    rr_arb2 u_port_arb (
        .clk       (ACLK),
        .rst       (ARESET),
        .req       (req_c),
        .en        (state_q == IDLE),
        .advance   (adv_c),
        .last_port (grant_q[1]),
        .gnt_c     (gnt_c)
    );

    // Request-side mux from the owning master; grant is one-hot so bit 1 selects.
    assign sel_p       = grant_q[1];
    assign sel_aw      = sel_p ? {S1_AXI.awaddr, S1_AXI.awprot} : {S0_AXI.awaddr, S0_AXI.awprot};
    assign sel_ar      = sel_p ? {S1_AXI.araddr, S1_AXI.arprot} : {S0_AXI.araddr, S0_AXI.arprot};
    assign sel_w       = sel_p ? {S1_AXI.wdata, S1_AXI.wstrb}   : {S0_AXI.wdata, S0_AXI.wstrb};
    assign sel_awvalid = sel_p ? S1_AXI.awvalid : S0_AXI.awvalid;
    assign sel_wvalid  = sel_p ? S1_AXI.wvalid  : S0_AXI.wvalid;
    assign sel_arvalid = sel_p ? S1_AXI.arvalid : S0_AXI.arvalid;
    assign sel_bready  = sel_p ? S1_AXI.bready  : S0_AXI.bready;
    assign sel_rready  = sel_p ? S1_AXI.rready  : S0_AXI.rready;

    assign in_wr = (state_q == WR_AW_W);
    assign in_b  = (state_q == WR_B);
    assign in_ar = (state_q == RD_AR);
    assign in_r  = (state_q == RD_R);

    assign M_AXI.awaddr  = sel_aw.addr;
    assign M_AXI.awprot  = sel_aw.prot;
    assign M_AXI.awvalid = in_wr & ~aw_done_q & sel_awvalid;
    assign M_AXI.wdata   = sel_w.data;
    assign M_AXI.wstrb   = sel_w.strb;
    assign M_AXI.wvalid  = in_wr & ~w_done_q & sel_wvalid;
    assign M_AXI.bready  = in_b & sel_bready;
    assign M_AXI.araddr  = sel_ar.addr;
    assign M_AXI.arprot  = sel_ar.prot;
    assign M_AXI.arvalid = in_ar & sel_arvalid;
    assign M_AXI.rready  = in_r & sel_rready;

    assign aw_hs = M_AXI.awvalid & M_AXI.awready;
    assign w_hs  = M_AXI.wvalid & M_AXI.wready;
    assign ar_hs = M_AXI.arvalid & M_AXI.arready;
    assign b_hs  = M_AXI.bvalid & M_AXI.bready;
    assign r_hs  = M_AXI.rvalid & M_AXI.rready;

    // Response-side routing; a channel already accepted stays closed to its master.
    assign awready_c = in_wr & ~aw_done_q & M_AXI.awready;
    assign wready_c  = in_wr & ~w_done_q & M_AXI.wready;
    assign arready_c = in_ar & M_AXI.arready;
    assign bvalid_c  = in_b & M_AXI.bvalid;
    assign rvalid_c  = in_r & M_AXI.rvalid;

    assign S0_AXI.awready = grant_q[0] & awready_c;
    assign S0_AXI.wready  = grant_q[0] & wready_c;
    assign S0_AXI.arready = grant_q[0] & arready_c;
    assign S0_AXI.bvalid  = grant_q[0] & bvalid_c;
    assign S0_AXI.rvalid  = grant_q[0] & rvalid_c;
    assign S0_AXI.bresp   = M_AXI.bresp;
    assign S0_AXI.rresp   = M_AXI.rresp;
    assign S0_AXI.rdata   = M_AXI.rdata;

    assign S1_AXI.awready = grant_q[1] & awready_c;
    assign S1_AXI.wready  = grant_q[1] & wready_c;
    assign S1_AXI.arready = grant_q[1] & arready_c;
    assign S1_AXI.bvalid  = grant_q[1] & bvalid_c;
    assign S1_AXI.rvalid  = grant_q[1] & rvalid_c;
    assign S1_AXI.bresp   = M_AXI.bresp;
    assign S1_AXI.rresp   = M_AXI.rresp;
    assign S1_AXI.rdata   = M_AXI.rdata;

    // Next-state logic: arbitration in IDLE, phase tracking elsewhere.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        tog_d       = tog_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        adv_c       = 1'b0;
        pick_port_c = gnt_c[1];
        pick_aw_c   = gnt_c[1] ? S1_AXI.awvalid : S0_AXI.awvalid;
        pick_ar_c   = gnt_c[1] ? S1_AXI.arvalid : S0_AXI.arvalid;
        kind_c      = (pick_aw_c && (!pick_ar_c || !tog_q[pick_port_c])) ? KIND_WR : KIND_RD;

        case (state_q)
            IDLE: begin
                if (gnt_c != 2'b00) begin
                    grant_d              = gnt_c;
                    tog_d[pick_port_c]   = ~tog_q[pick_port_c];
                    aw_done_d            = 1'b0;
                    w_done_d             = 1'b0;
                    state_d              = (kind_c == KIND_WR) ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_B;
                end
            end
            WR_B: begin
                if (b_hs) begin
                    adv_c   = 1'b1;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            RD_AR: begin
                if (ar_hs) state_d = RD_R;
            end
            RD_R: begin
                if (r_hs) begin
                    adv_c   = 1'b1;
                    grant_d = 2'b00;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            tog_q     <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            tog_q     <= tog_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = busy_q;

endmodule
